// File: rtl/codec_pkg.sv
// Shared block-codec constants: 8x8 geometry, JPEG zigzag scan table, bank states.
// Pure definitions; no logic, no latency.
package codec_pkg;

   localparam int BLK_N  = 8;
   localparam int BLK_SZ = BLK_N * BLK_N;

   // Entry k is the raster index (v*8+u) of the k-th coefficient in zigzag order.
   localparam logic [5:0] ZIGZAG_LUT [0:BLK_SZ-1] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_state_t;

   function automatic logic [5:0] raster_addr(input logic [2:0] u, input logic [2:0] v);
      return {v, u};
   endfunction

endpackage

// File: rtl/zz_bank_ram.sv
// Two-bank coefficient store addressed {bank, addr6}: write lands on the clock edge,
// read is combinational so the drain side can load its output register in one cycle.
module zz_bank_ram
   import codec_pkg::*;
#(
   parameter int COEF_W = 12
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [6:0]        waddr_i,
   input  logic [COEF_W-1:0] wdata_i,
   input  logic [6:0]        raddr_i,
   output logic [COEF_W-1:0] rdata_o
);

   logic [COEF_W-1:0] mem_q [0:2*BLK_SZ-1];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/zigzag_reorder.sv
// Ping-pong 8x8 raster-to-zigzag reorder: first output one edge after the completing write,
// in_ready drops only when the write bank is still FULL; output register holds under out_ready=0.
module zigzag_reorder
   import codec_pkg::*;
#(
   parameter int COEF_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_u,
   input  logic [2:0]        in_v,
   input  logic [COEF_W-1:0] in_coef,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [COEF_W-1:0] out_coef,
   output logic [5:0]        out_idx,
   output logic              out_last
);

   bank_state_t       bank_q [2];
   bank_state_t       bank_d [2];
   logic              wb_q, wb_d;
   logic              rb_q, rb_d;
   logic [6:0]        fcnt_q, fcnt_d;
   logic [5:0]        dp_q, dp_d;

   logic              out_valid_q, out_valid_d;
   logic [COEF_W-1:0] out_coef_q, out_coef_d;
   logic [5:0]        out_idx_q, out_idx_d;
   logic              out_last_q, out_last_d;

   logic              wr_fire;
   logic              ld_en;
   logic              clr;
   logic [5:0]        lut_addr;
   logic [COEF_W-1:0] rd_data;

   assign clr      = rst || flush;
   assign in_ready = (bank_q[wb_q] != FULL);
   assign wr_fire  = in_valid && in_ready;
   assign ld_en    = !out_valid_q || out_ready;
   assign lut_addr = ZIGZAG_LUT[dp_q];

   zz_bank_ram #(
      .COEF_W (COEF_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_fire && !clr),
      .waddr_i ({wb_q, raster_addr(in_u, in_v)}),
      .wdata_i (in_coef),
      .raddr_i ({rb_q, lut_addr}),
      .rdata_o (rd_data)
   );

   // A write can only target a non-FULL bank and a drain only a FULL one, so when both
   // fire in one cycle they always touch different banks and both updates stand.
   always_comb begin
      bank_d      = bank_q;
      wb_d        = wb_q;
      rb_d        = rb_q;
      fcnt_d      = fcnt_q;
      dp_d        = dp_q;
      out_valid_d = out_valid_q;
      out_coef_d  = out_coef_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;

      if (wr_fire) begin
         if (fcnt_q == 7'(BLK_SZ - 1)) begin
            bank_d[wb_q] = FULL;
            wb_d         = !wb_q;
            fcnt_d       = '0;
         end else begin
            bank_d[wb_q] = FILLING;
            fcnt_d       = fcnt_q + 7'd1;
         end
      end

      if (ld_en) begin
         if (bank_q[rb_q] == FULL) begin
            out_valid_d = 1'b1;
            out_coef_d  = rd_data;
            out_idx_d   = dp_q;
            out_last_d  = (dp_q == 6'(BLK_SZ - 1));
            dp_d        = dp_q + 6'd1;
            if (dp_q == 6'(BLK_SZ - 1)) begin
               bank_d[rb_q] = EMPTY;
               rb_d         = !rb_q;
            end
         end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
      end
   end

   // Memory contents are deliberately left untouched by rst/flush.
   always_ff @(posedge clk) begin
      if (clr) begin
         bank_q[0]   <= EMPTY;
         bank_q[1]   <= EMPTY;
         wb_q        <= 1'b0;
         rb_q        <= 1'b0;
         fcnt_q      <= '0;
         dp_q        <= '0;
         out_valid_q <= 1'b0;
         out_coef_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         bank_q      <= bank_d;
         wb_q        <= wb_d;
         rb_q        <= rb_d;
         fcnt_q      <= fcnt_d;
         dp_q        <= dp_d;
         out_valid_q <= out_valid_d;
         out_coef_q  <= out_coef_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_coef  = out_coef_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_zigzag_reorder.sv
// Bench for zigzag_reorder: scoreboard fed by a ping-pong block model, zigzag order built by diagonal walk.
module tb_zigzag_reorder;

   localparam int COEF_W = 12;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_u;
   logic [2:0]        in_v;
   logic [COEF_W-1:0] in_coef;
   logic              out_valid;
   logic              out_ready;
   logic [COEF_W-1:0] out_coef;
   logic [5:0]        out_idx;
   logic              out_last;

   zigzag_reorder #(.COEF_W(COEF_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_u      (in_u),
      .in_v      (in_v),
      .in_coef   (in_coef),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_coef  (out_coef),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int stalls = 0;

   typedef struct {
      int coef;
      int idx;
   } exp_t;

   typedef struct {
      int n;
      int coef;
      int idx;
      int last;
   } vec_t;

   int    zz [64];
   int    img [2][64];
   int    par;
   int    wcnt;
   exp_t  expq [$];
   exp_t  mon_e;
   vec_t  tbl [12];

   int    log_coef [512];
   int    log_idx  [512];
   int    log_last [512];
   int    log_cyc  [512];
   int    log_n;

   bit    hold_p;
   int    hold_coef;
   int    hold_idx;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      wcnt = 0;
      par  = 0;
      expq.delete();
   endfunction

   function automatic void model_write(input int u, input int v, input int c);
      exp_t e;
      img[par][v*8+u] = c;
      wcnt++;
      if (wcnt == 64) begin
         for (int k = 0; k < 64; k++) begin
            e.coef = img[par][zz[k]];
            e.idx  = k;
            expq.push_back(e);
         end
         wcnt = 0;
         par  = 1 - par;
      end
   endfunction

   // Output monitor: everything accepted must match the scoreboard; held data must not move.
   always @(negedge clk) begin
      if (!rst && !flush) begin
         if (hold_p) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_coef", int'(out_coef), hold_coef);
            check("hold_idx", int'(out_idx), hold_idx);
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: idx %0d coef %0d, expected no output", out_idx, out_coef);
            end else begin
               mon_e = expq.pop_front();
               check("out_coef", int'(out_coef), mon_e.coef);
               check("out_idx", int'(out_idx), mon_e.idx);
               check("out_last", int'(out_last), (mon_e.idx == 63) ? 1 : 0);
            end
            if (log_n < 512) begin
               log_coef[log_n] = int'(out_coef);
               log_idx[log_n]  = int'(out_idx);
               log_last[log_n] = int'(out_last);
               log_cyc[log_n]  = cyc;
            end
            log_n++;
         end
         hold_p    = out_valid && !out_ready;
         hold_coef = int'(out_coef);
         hold_idx  = int'(out_idx);
      end else begin
         hold_p = 1'b0;
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic wr(input int u, input int v, input int c, output int acc_cyc);
      int  waited;
      bit  done;
      waited   = 0;
      done     = 1'b0;
      acc_cyc  = -1;
      in_valid = 1'b1;
      in_u     = 3'(u);
      in_v     = 3'(v);
      in_coef  = COEF_W'(c);
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            model_write(u, v, c);
            acc_cyc = cyc;
            done    = 1'b1;
         end else begin
            stalls++;
            waited++;
            if (waited > 3000) begin
               tests++;
               fails++;
               $display("FAIL write_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
               in_valid = 1'b0;
               done     = 1'b1;
            end else begin
               @(posedge clk);
               #1;
            end
         end
      end
   endtask

   task automatic wr_ramp(input int base, output int last_cyc);
      for (int v = 0; v < 8; v++) begin
         for (int u = 0; u < 8; u++) begin
            wr(u, v, base + v*8 + u, last_cyc);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n;
      n = 0;
      while (expq.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (expq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d outputs still pending, expected 0", expq.size());
         expq.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_tbl(input int off_n, input int off_coef);
      for (int i = 0; i < 12; i++) begin
         check("tbl_coef", log_coef[tbl[i].n + off_n], tbl[i].coef + off_coef);
         check("tbl_idx", log_idx[tbl[i].n + off_n], tbl[i].idx);
         check("tbl_last", log_last[tbl[i].n + off_n], tbl[i].last);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, kacc, lastc, cnt, prev_rdy;
      bit found;
      int perm [64];
      bit wr_done;

      k = 0;
      for (int s = 0; s < 15; s++) begin
         if (s % 2 == 0) begin
            for (int v = (s < 8) ? s : 7; v >= 0 && (s - v) < 8; v--) begin
               zz[k] = v*8 + (s - v);
               k++;
            end
         end else begin
            for (int v = (s > 7) ? s - 7 : 0; v <= s && v < 8; v++) begin
               zz[k] = v*8 + (s - v);
               k++;
            end
         end
      end

      tbl[0]  = '{0, 0, 0, 0};
      tbl[1]  = '{1, 1, 1, 0};
      tbl[2]  = '{2, 8, 2, 0};
      tbl[3]  = '{3, 16, 3, 0};
      tbl[4]  = '{4, 9, 4, 0};
      tbl[5]  = '{5, 2, 5, 0};
      tbl[6]  = '{6, 3, 6, 0};
      tbl[7]  = '{7, 10, 7, 0};
      tbl[8]  = '{14, 4, 14, 0};
      tbl[9]  = '{20, 40, 20, 0};
      tbl[10] = '{35, 56, 35, 0};
      tbl[11] = '{63, 63, 63, 1};

      hold_p = 1'b0;
      log_n  = 0;
      model_reset();

      // Reset held for two cycles with a write request present.
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_u      = 3'd3;
      in_v      = 3'd5;
      in_coef   = 12'd123;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_idx", int'(out_idx), 0);
      check("rst_out_coef", int'(out_coef), 0);
      check("rst_out_last", int'(out_last), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("post_rst_no_output", int'(out_valid), 0);
      end
      @(posedge clk);
      #1;

      // Single raster ramp block: latency and zigzag sequence.
      log_n = 0;
      wr_ramp(0, kacc);
      wait_drain(300);
      check("blk1_count", log_n, 64);
      check("blk1_first_latency", log_cyc[0] - kacc, 1);
      check_tbl(0, 0);
      cnt = 0;
      for (int i = 0; i < 64; i++) cnt += log_last[i];
      check("blk1_last_count", cnt, 1);

      // Three back-to-back blocks: no write stall, no output bubble.
      log_n  = 0;
      stalls = 0;
      for (int b = 0; b < 3; b++) wr_ramp(b*64, kacc);
      wait_drain(400);
      check("b2b_stalls", stalls, 0);
      check("b2b_count", log_n, 192);
      check("b2b_contiguous", log_cyc[191] - log_cyc[0], 191);
      check_tbl(128, 128);

      // Backpressure: two full banks, then drain.
      log_n     = 0;
      out_ready = 1'b0;
      wr_ramp(0, kacc);
      wr_ramp(64, kacc);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_out_coef", int'(out_coef), 0);
         check("bp_out_idx", int'(out_idx), 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      found     = 1'b0;
      prev_rdy  = int'(in_ready);
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (out_valid && out_idx == 6'd63) begin
            check("bp_ready_before_63", prev_rdy, 0);
            check("bp_ready_after_63", int'(in_ready), 1);
            found = 1'b1;
         end
         prev_rdy = int'(in_ready);
      end
      check("bp_idx63_seen", int'(found), 1);
      @(posedge clk);
      #1;
      wait_drain(300);
      check("bp_count", log_n, 128);

      // Flush a partial block; the next block starts clean.
      log_n = 0;
      for (int i = 0; i < 30; i++) wr(i % 8, i / 8, 2000 + i, kacc);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_u     = 3'd7;
      in_v     = 3'd7;
      in_coef  = 12'd5;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      check("flush_in_ready", int'(in_ready), 1);
      check("flush_out_valid", int'(out_valid), 0);
      repeat (4) begin
         @(negedge clk);
         check("flush_no_output", int'(out_valid), 0);
      end
      @(posedge clk);
      #1;
      wr_ramp(0, kacc);
      wait_drain(300);
      check("flush_count", log_n, 64);
      check_tbl(0, 0);

      // Reset mid-drain while out_idx 20 is presented.
      log_n = 0;
      wr_ramp(300, kacc);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (out_valid && out_idx == 6'd19) found = 1'b1;
      end
      check("mid_idx19_seen", int'(found), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("mid_idx20_present", int'(out_idx), 20);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_out_idx", int'(out_idx), 0);
      check("mid_rst_out_coef", int'(out_coef), 0);
      check("mid_rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      log_n = 0;
      wr_ramp(1000, kacc);
      wait_drain(300);
      check("mid_new_count", log_n, 64);
      check("mid_new_first_idx", log_idx[0], 0);
      check("mid_new_first_coef", log_coef[0], 1000);

      // Random: shuffled addresses, duplicates in later blocks, gaps, random backpressure.
      log_n   = 0;
      wr_done = 1'b0;
      fork
         begin
            for (int b = 0; b < 6; b++) begin
               for (int i = 0; i < 64; i++) perm[i] = i;
               for (int i = 63; i > 0; i--) begin
                  int j, t;
                  j = $urandom_range(0, i);
                  t = perm[i];
                  perm[i] = perm[j];
                  perm[j] = t;
               end
               if (b >= 2) perm[$urandom_range(1, 63)] = perm[0];
               for (int i = 0; i < 64; i++) begin
                  int c;
                  if ($urandom_range(0, 3) == 0) begin
                     in_valid = 1'b0;
                     @(posedge clk);
                     #1;
                  end
                  c = $urandom_range(0, 4095);
                  wr(perm[i] % 8, perm[i] / 8, c, kacc);
               end
            end
            in_valid = 1'b0;
            wr_done  = 1'b1;
         end
         begin
            while (!wr_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain(2000);
      check("rand_count", log_n, 384);

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
